// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbiter with registered one-hot grant and bounded hold time
module rr_arbiter_n #(
  parameter int N = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state;
  logic [IDW-1:0] ptr, start, win, win_nxt, owner_nxt;
  logic [7:0] hold_cnt;
  logic [N-1:0] cand;
  logic owner_req, at_max, others, keep, found;
  always_comb begin
    owner_nxt = grant_id == IDW'(N-1) ? '0 : grant_id + 1'b1;
    owner_req = req[grant_id];
    at_max = hold_cnt >= 8'(MAX_HOLD);
    others = |(req & ~grant);
    keep = state == GRANTED && owner_req && (!at_max || !others);
    cand = state == GRANTED && owner_req ? req & ~grant : req;
    start = state == IDLE ? ptr : owner_nxt;
    found = 1'b0;
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && cand[IDW'((int'(start) + i) % N)]) begin
        found = 1'b1;
        win = IDW'((int'(start) + i) % N);
      end
    end
    win_nxt = win == IDW'(N-1) ? '0 : win + 1'b1;
  end
  // grant_id doubles as the owner index while GRANTED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
    end else if (keep) begin
      hold_cnt <= at_max ? hold_cnt : hold_cnt + 8'd1;
    end else if (found) begin
      state <= GRANTED;
      ptr <= win_nxt;
      hold_cnt <= 8'd1;
      grant <= N'(1) << win;
      grant_id <= win;
      grant_valid <= 1'b1;
    end else begin
      state <= IDLE;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed vector table plus reset and rotation sequences
module tb_rr_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic grant_valid;
  logic [4:0] req5 = '0;
  logic [4:0] grant5;
  logic [2:0] grant_id5;
  logic grant_valid5;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    int         cnt;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } vec_t;

  vec_t vecs[20] = '{
    '{4'b0101, 1, 4'b0001, 2'd0, 1'b1},
    '{4'b0100, 1, 4'b0100, 2'd2, 1'b1},
    '{4'b0100, 9, 4'b0100, 2'd2, 1'b1},
    '{4'b0000, 1, 4'b0000, 2'd0, 1'b0},
    '{4'b1111, 4, 4'b1000, 2'd3, 1'b1},
    '{4'b1111, 4, 4'b0001, 2'd0, 1'b1},
    '{4'b1111, 4, 4'b0010, 2'd1, 1'b1},
    '{4'b1111, 4, 4'b0100, 2'd2, 1'b1},
    '{4'b1111, 4, 4'b1000, 2'd3, 1'b1},
    '{4'b1111, 1, 4'b0001, 2'd0, 1'b1},
    '{4'b0010, 1, 4'b0010, 2'd1, 1'b1},
    '{4'b1001, 1, 4'b1000, 2'd3, 1'b1},
    '{4'b0001, 1, 4'b0001, 2'd0, 1'b1},
    '{4'b0000, 2, 4'b0000, 2'd0, 1'b0},
    '{4'b0011, 4, 4'b0010, 2'd1, 1'b1},
    '{4'b0011, 4, 4'b0001, 2'd0, 1'b1},
    '{4'b0011, 1, 4'b0010, 2'd1, 1'b1},
    '{4'b1000, 10, 4'b1000, 2'd3, 1'b1},
    '{4'b1001, 1, 4'b0001, 2'd0, 1'b1},
    '{4'b0100, 1, 4'b0100, 2'd2, 1'b1}
  };

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid)
  );

  rr_arbiter_n #(.N(5), .MAX_HOLD(1)) dut5 (
    .clk(clk), .rst(rst), .req(req5),
    .grant(grant5), .grant_id(grant_id5), .grant_valid(grant_valid5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] id, input logic v);
    chk({nm, ".grant"}, 32'(grant), 32'(g));
    chk({nm, ".grant_id"}, 32'(grant_id), 32'(id));
    chk({nm, ".grant_valid"}, 32'(grant_valid), 32'(v));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_out("reset_async", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111;
    @(posedge clk); #1;
    chk_out("reset_ignores_req", 4'b0000, 2'd0, 1'b0);
    req = '0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req = vecs[i].req;
      for (int c = 0; c < vecs[i].cnt; c++) begin
        @(posedge clk); #1;
        chk_out($sformatf("vec%0d.cyc%0d", i, c), vecs[i].g, vecs[i].id, vecs[i].v);
      end
    end
    // mid-grant reset must drop the grant before any clock edge
    #2 rst = 1'b1;
    #1 chk_out("mid_grant_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b1010;
    @(posedge clk); #1;
    chk_out("rst_held", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_out("after_rst_ptr0", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    @(posedge clk); #1;
    chk_out("after_rst_idle", 4'b0000, 2'd0, 1'b0);
    // MAX_HOLD=1 with N=5 rotates every cycle, including the wrap at 4
    req5 = 5'b11111;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rot5.grant%0d", k), 32'(grant5), 32'(5'b00001 << (k % 5)));
      chk($sformatf("rot5.id%0d", k), 32'(grant_id5), 32'(k % 5));
      chk($sformatf("rot5.valid%0d", k), 32'(grant_valid5), 32'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles for one owner while others wait; legal range 1..255.
REQ-003 Parameter IDW, default $clog2(N), width of grant_id; derived from N and not overridden.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  N  request vector; bit i set = requester i wants the resource.
REQ-007 grant  output  N  registered grant; one-hot or all-zero.
REQ-008 grant_id  output  IDW  binary index of the asserted grant bit; 0 when grant_valid=0.
REQ-009 grant_valid  output  1  high when grant is non-zero.

Function
REQ-010 Internal state: ptr (IDW bits, next search start), owner index, hold_cnt (8 bits), state in {IDLE, GRANTED}.
REQ-011 Search rule: the winner is the first set bit of the candidate set scanning cyclically from the start index, so index start, start+1, ... N-1, 0, ... wrap mod N.
REQ-012 IDLE, req=0: stay IDLE; grant=0, grant_valid=0.
REQ-013 IDLE, req!=0: the search starts at ptr over req, winner k; next edge: grant[k]=1, grant_id=k, grant_valid=1, hold_cnt=1, ptr=(k+1) mod N, state GRANTED.
REQ-014 Latency from request to grant shall be exactly one clock edge; grant never changes between edges except on rst.
REQ-015 GRANTED owner k, req[k]=0 (release): the search starts at (k+1) mod N over req; if a winner j exists, grant j at the next edge with hold_cnt=1 and ptr=(j+1) mod N, with no idle cycle; otherwise grant=0 and state IDLE at the next edge.
REQ-016 GRANTED owner k, req[k]=1, hold_cnt<MAX_HOLD: keep grant k and increment hold_cnt.
REQ-017 GRANTED owner k, req[k]=1, hold_cnt=MAX_HOLD, other req bits set: preempt; the search starts at (k+1) mod N over req with bit k masked off; winner j is granted at the next edge with hold_cnt=1 and ptr=(j+1) mod N.
REQ-018 GRANTED owner k, req[k]=1, hold_cnt=MAX_HOLD, no other req: keep grant k; hold_cnt saturates at MAX_HOLD and does not wrap.
REQ-019 MAX_HOLD=1 with N requesters continuously asserted shall rotate the grant every cycle.
REQ-020 A requester dropping req in the same cycle it would have won the search shall not be granted; the search uses the current-cycle req only.
REQ-021 Fairness: with all N requesters asserted continuously, each requester shall receive exactly MAX_HOLD consecutive grant cycles per rotation of N*MAX_HOLD cycles.
REQ-022 grant shall never assert a bit whose req was 0 in the cycle the grant decision was made.

Reset
REQ-023 rst=1 shall force, without waiting for a clk edge: grant=0, grant_id=0, grant_valid=0, ptr=0, hold_cnt=0, state IDLE.
REQ-024 While rst=1, req shall be ignored; the first grant may appear at the first rising edge after rst falls.
REQ-025 rst asserted mid-grant shall drop the grant immediately; priority restarts from index 0.

Verification (N=4, MAX_HOLD=4)
REQ-026 After reset, req=0101 -> next edge grant=0001, id=0; then req=0100 -> next edge grant=0100, id=2, with no zero cycle.
REQ-027 req=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ...; grant_valid continuously 1.
REQ-028 req=0100 alone held 10 cycles -> grant=0100 for all 10 cycles with hold_cnt saturated at 4; req=0000 -> next edge grant=0000, grant_valid=0.
REQ-029 Owner 1 (grant=0010) releases with req=1001 -> next grant 1000 (search from 2); 1000 releases with req=0001 -> grant 0001.
REQ-030 Grant held at 0100, rst pulsed between edges -> grant=0000 immediately; after rst low, req=1010 -> next edge grant=0010 (ptr=0).
REQ-031 Owner 2 releases to idle (ptr=3), then req=1111 -> next edge grant=1000, id=3.
